// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external combinational ALU: IDLE -> EXEC -> WB per operation.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
module alu_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [3:0]  op0,
   input  logic [3:0]  op1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] result,
   output logic        err,
   output logic        busy,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        winner_q, winner_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;
   logic        pick1;
   logic        divZero;

   // winner_q doubles as the last-winner record; its reset value of 1 lets requester 0 win the first tie
`ifdef ALU_ARB_ROUND_ROBIN_EN
   assign pick1 = req1 & (~req0 | ~winner_q);
`else
   assign pick1 = req1 & ~req0;
`endif

   assign divZero = (op_q == 4'd3) && (b_q == 32'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         winner_q <= 1'b1;
         op_q     <= 4'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         result_q <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         IDLE, WB: begin
            if (req0 | req1) begin
               state_d  = EXEC;
               winner_d = pick1;
               op_d     = pick1 ? op1 : op0;
               a_d      = pick1 ? a1 : a0;
               b_d      = pick1 ? b1 : b0;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            // a zero divisor overrides whatever the external ALU produces
            state_d  = WB;
            result_d = divZero ? 32'd0 : alu_out;
            err_d    = divZero;
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt0   = (state_q == EXEC) & ~winner_q;
   assign gnt1   = (state_q == EXEC) &  winner_q;
   assign done0  = (state_q == WB)   & ~winner_q;
   assign done1  = (state_q == WB)   &  winner_q;
   assign err    = (state_q == WB)   &  err_q;
   assign busy   = (state_q != IDLE);
   assign result = result_q;
   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign alu_op = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: the bench plays the external ALU and both requesters,
// predicts each completion from an arithmetic model, and a monitor checks every done pulse.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, req1;
   logic [3:0]  op0, op1;
   logic [31:0] a0, b0, a1, b1;
   logic        gnt0, gnt1, done0, done1, err, busy;
   logic [31:0] result, aluA, aluB, aluOut;
   logic [3:0]  aluOp;

   typedef struct {
      logic        who;
      logic [31:0] res;
      logic        err;
   } exp_t;

   exp_t expQ[$];
   int   testsRun = 0;
   int   testsFailed = 0;
   logic modelLast = 1'b1;

   function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a * b;
         4'd3:  return (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
         4'd4:  return a & b;
         4'd5:  return a | b;
         4'd6:  return a ^ b;
         4'd7:  return ~a;
         4'd8:  return a;
         4'd9:  return b;
         4'd10: return a << b[4:0];
         4'd11: return a >> b[4:0];
         4'd12: return $unsigned($signed(a) >>> b[4:0]);
         4'd13: return a + 32'd4;
         4'd14: return a - 32'd4;
         default: return 32'($countones(a));
      endcase
   endfunction

   assign aluOut = aluRef(aluOp, aluA, aluB);

   alu_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .err(err), .busy(busy),
      .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp), .alu_out(aluOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic tieWinner();
`ifdef ALU_ARB_ROUND_ROBIN_EN
      return ~modelLast;
`else
      return 1'b0;
`endif
   endfunction

   task automatic pushExp(input logic who, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic dz;
      dz    = (op == 4'd3) && (b == 32'd0);
      e.who = who;
      e.err = dz;
      e.res = dz ? 32'd0 : aluRef(op, a, b);
      expQ.push_back(e);
      modelLast = who;
   endtask

   task automatic waitGnt(output int waited);
      waited = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         waited++;
         if (gnt0 | gnt1) break;
      end
      check("gntSeen", {31'd0, gnt0 | gnt1}, 32'd1);
   endtask

   task automatic driveReq(input logic who, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!who) begin
         req0 = 1'b1; op0 = op; a0 = a; b0 = b;
      end else begin
         req1 = 1'b1; op1 = op; a1 = a; b1 = b;
      end
   endtask

   task automatic dropReq(input logic who);
      if (!who) req0 = 1'b0;
      else      req1 = 1'b0;
   endtask

   task automatic applyStimulus(input logic who, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit checkLat);
      int waited;
      driveReq(who, op, a, b);
      pushExp(who, op, a, b);
      waitGnt(waited);
      if (checkLat) check("gntLatency", 32'(waited), 32'd1);
      check("gntWho", {30'd0, gnt1, gnt0}, who ? 32'd2 : 32'd1);
      check("aluA", aluA, a);
      check("aluB", aluB, b);
      check("aluOp", {28'd0, aluOp}, {28'd0, op});
      dropReq(who);
   endtask

   task automatic applyPair(input logic [3:0] opx, input logic [31:0] ax, input logic [31:0] bx,
                            input logic [3:0] opy, input logic [31:0] ay, input logic [31:0] by);
      logic w;
      int   waited;
      driveReq(1'b0, opx, ax, bx);
      driveReq(1'b1, opy, ay, by);
      w = tieWinner();
      if (!w) begin
         pushExp(1'b0, opx, ax, bx);
         pushExp(1'b1, opy, ay, by);
      end else begin
         pushExp(1'b1, opy, ay, by);
         pushExp(1'b0, opx, ax, bx);
      end
      waitGnt(waited);
      check("pairFirst", {30'd0, gnt1, gnt0}, w ? 32'd2 : 32'd1);
      check("pairFirstA", aluA, w ? ay : ax);
      dropReq(w);
      waitGnt(waited);
      check("pairSecond", {30'd0, gnt1, gnt0}, w ? 32'd1 : 32'd2);
      check("pairSecondA", aluA, w ? ax : ay);
      dropReq(~w);
   endtask

   task automatic checkOutput();
      check("resetCtl", {26'd0, gnt0, gnt1, done0, done1, err, busy}, 32'd0);
      check("resetResult", result, 32'd0);
      check("resetAluA", aluA, 32'd0);
      check("resetAluB", aluB, 32'd0);
      check("resetAluOp", {28'd0, aluOp}, 32'd0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      expQ.delete();
      modelLast = 1'b1;
      #1 checkOutput();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Every done pulse must match the oldest outstanding prediction
   always @(negedge clk) begin
      if (!rst && (done0 || done1)) begin
         check("doneExcl", {31'd0, done0 & done1}, 32'd0);
         if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedDone: done0=%0b done1=%0b with nothing outstanding", done0, done1);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            check("doneWho", {31'd0, done1}, {31'd0, e.who});
            check("result", result, e.res);
            check("err", {31'd0, err}, {31'd0, e.err});
         end
      end
   end

   initial begin
      int waited;
      int busyCount;
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      op0 = 4'd0; op1 = 4'd0;
      a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
      @(negedge clk);
      checkOutput();
      rst = 1'b0;
      @(negedge clk);

      // add 5+7, fixed latency, busy for exactly two cycles
      applyStimulus(1'b0, 4'd0, 32'd5, 32'd7, 1'b1);
      busyCount = int'(busy);
      @(negedge clk);
      check("done0Latency", {31'd0, done0}, 32'd1);
      busyCount += int'(busy);
      repeat (4) begin
         @(negedge clk);
         busyCount += int'(busy);
      end
      check("busyCycles", 32'(busyCount), 32'd2);

      // both requesters held high: policy decides every accept, one op per two cycles
      doReset();
      driveReq(1'b0, 4'd1, 32'd10, 32'd3);
      driveReq(1'b1, 4'd1, 32'd10, 32'd3);
      for (int k = 0; k < 4; k++) begin
         logic w;
         w = tieWinner();
         pushExp(w, 4'd1, 32'd10, 32'd3);
         waitGnt(waited);
         if (k > 0) check("heldSpacing", 32'(waited), 32'd2);
         check("heldWho", {30'd0, gnt1, gnt0}, w ? 32'd2 : 32'd1);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (3) @(negedge clk);

      // divide by zero, then a normal divide back to back
      applyStimulus(1'b1, 4'd3, 32'd100, 32'd0, 1'b1);
      applyStimulus(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
      repeat (3) @(negedge clk);

      // hamming weight and arithmetic shift right
      applyStimulus(1'b1, 4'd15, 32'hFFFF_FFFF, 32'd0, 1'b1);
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 4'd12, 32'h8000_0000, 32'd4, 1'b1);
      repeat (3) @(negedge clk);

      // randomized traffic: single requests and simultaneous pairs
      for (int n = 0; n < 40; n++) begin
         logic [3:0]  opr, ops;
         logic [31:0] ar, br, as, bs;
         int          mode;
         mode = $urandom_range(0, 2);
         opr = 4'($urandom_range(0, 15));
         ops = 4'($urandom_range(0, 15));
         ar = $urandom; as = $urandom;
         br = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         bs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         if (mode == 2) applyPair(opr, ar, br, ops, as, bs);
         else applyStimulus(mode == 1, opr, ar, br, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (3) @(negedge clk);

      // reset during EXEC aborts the operation without a done pulse
      driveReq(1'b0, 4'd2, 32'd6, 32'd9);
      waitGnt(waited);
      check("abortGnt", {30'd0, gnt1, gnt0}, 32'd1);
      rst = 1'b1;
      req0 = 1'b0;
      expQ.delete();
      modelLast = 1'b1;
      #1 checkOutput();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abortIdle", {31'd0, busy}, 32'd0);
      applyStimulus(1'b0, 4'd6, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);

      for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
      check("drain", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
